spi_ram_responder: RTL

SPI_RAM_RESPONDER -- requirements
Module: spi_ram_responder

---
 rtl/spi_ram_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/spi_ram_responder.sv
// SPI-style byte RAM responder: 8-bit command, 24-bit address, then streamed
// read or write data, all advanced by cpu_clk cycles that carry an SPI bit.
module spi_ram_responder #(
  parameter int ADDR_BITS = 8  // valid range 2..24
) (
  input  logic cpu_clk,
  input  logic rstn,
  input  logic spi_select,
  input  logic spi_clk_en,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    READ   = 3'd3,
    WRITE  = 3'd4,
    IGNORE = 3'd5
  } state_t;

  localparam int                   DEPTH     = 1 << ADDR_BITS;
  localparam logic [7:0]           CMD_READ  = 8'h03;
  localparam logic [7:0]           CMD_WRITE = 8'h02;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE  = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [7:0]           mem_r [DEPTH];
  state_t               state_r;
  logic [4:0]           bit_cnt_r;
  logic [7:0]           cmd_r;
  logic [6:0]           wbyte_r;
  logic [ADDR_BITS-1:0] addr_r;
  logic                 armed_r;

  logic                 shift_s;
  logic                 mem_we_s;
  logic [7:0]           cmd_shift_s;
  logic [7:0]           wbyte_shift_s;
  logic [ADDR_BITS-1:0] addr_shift_s;
  logic [ADDR_BITS-1:0] addr_inc_s;
  logic [7:0]           rd_byte_s;
  logic [7:0]           next_byte_s;
  logic [7:0]           first_byte_s;

  assign shift_s       = ~spi_select & spi_clk_en;
  assign cmd_shift_s   = {cmd_r[6:0], spi_mosi};
  assign wbyte_shift_s = {wbyte_r, spi_mosi};
  // Only the low ADDR_BITS of the 24-bit address survive the shift.
  assign addr_shift_s  = {addr_r[ADDR_BITS-2:0], spi_mosi};
  assign addr_inc_s    = addr_r + ADDR_ONE;
  assign rd_byte_s     = mem_r[addr_r];
  assign next_byte_s   = mem_r[addr_inc_s];
  assign first_byte_s  = mem_r[addr_shift_s];
  assign mem_we_s      = rstn & shift_s & (state_r == WRITE) & (bit_cnt_r[2:0] == 3'd7);

  // Storage write port; contents are deliberately left untouched by reset.
  always_ff @(posedge cpu_clk) begin
    if (mem_we_s) begin
      mem_r[addr_r] <= wbyte_shift_s;
    end
  end

  // Protocol FSM with registered spi_miso and busy.
  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      state_r   <= IDLE;
      spi_miso  <= 1'b0;
      busy      <= 1'b0;
      bit_cnt_r <= 5'd0;
      addr_r    <= '0;
      cmd_r     <= 8'h00;
      wbyte_r   <= 7'd0;
      armed_r   <= 1'b0;  // bus stays ignored until a deselect is observed
    end else if (spi_select) begin
      state_r   <= IDLE;
      spi_miso  <= 1'b0;
      busy      <= 1'b0;
      bit_cnt_r <= 5'd0;
      armed_r   <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (armed_r) begin
            state_r <= CMD;
            busy    <= 1'b1;
            if (spi_clk_en) begin
              cmd_r     <= cmd_shift_s;
              bit_cnt_r <= 5'd1;
            end
          end
        end
        CMD: begin
          if (shift_s) begin
            cmd_r     <= cmd_shift_s;
            bit_cnt_r <= bit_cnt_r + 5'd1;
            if (bit_cnt_r == 5'd7) begin
              state_r <= ((cmd_shift_s == CMD_READ) || (cmd_shift_s == CMD_WRITE)) ? ADDR : IGNORE;
            end
          end
        end
        ADDR: begin
          if (shift_s) begin
            addr_r    <= addr_shift_s;
            bit_cnt_r <= bit_cnt_r + 5'd1;  // 31 wraps to 0 for the data phase
            if (bit_cnt_r == 5'd31) begin
              if (cmd_r == CMD_READ) begin
                state_r  <= READ;
                spi_miso <= first_byte_s[7];
              end else begin
                state_r  <= WRITE;
              end
            end
          end
        end
        READ: begin
          if (shift_s) begin
            bit_cnt_r <= {2'b00, bit_cnt_r[2:0] + 3'd1};
            if (bit_cnt_r[2:0] == 3'd7) begin
              addr_r   <= addr_inc_s;
              spi_miso <= next_byte_s[7];
            end else begin
              spi_miso <= rd_byte_s[3'd6 - bit_cnt_r[2:0]];
            end
          end
        end
        WRITE: begin
          if (shift_s) begin
            wbyte_r   <= wbyte_shift_s[6:0];
            bit_cnt_r <= {2'b00, bit_cnt_r[2:0] + 3'd1};
            if (bit_cnt_r[2:0] == 3'd7) begin
              addr_r <= addr_inc_s;
            end
          end
        end
        IGNORE: begin
          spi_miso <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          spi_miso <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
